// File: rtl/dot_product_unit_if.sv
// Memory-read and result bus between dot_product_unit and its neighbours.
// The slave side is the dot product unit; the master side is the controller, memory and mem_writer.
interface dot_product_unit_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int RESULT_WIDTH = 2*DATA_WIDTH + $clog2(VECTOR_WIDTH)
) ();
    logic                    start;
    logic [ADDR_WIDTH-1:0]   base_addr_a;
    logic [ADDR_WIDTH-1:0]   base_addr_b;
    logic                    read_en;
    logic [ADDR_WIDTH-1:0]   read_address;
    logic [DATA_WIDTH-1:0]   read_data;
    logic [RESULT_WIDTH-1:0] dot_product_result;
    logic                    result_valid;
    logic                    processing_done;
    logic                    busy;

    modport slave (
        input  start, base_addr_a, base_addr_b, read_data,
        output read_en, read_address, dot_product_result, result_valid, processing_done, busy
    );

    modport master (
        output start, base_addr_a, base_addr_b, read_data,
        input  read_en, read_address, dot_product_result, result_valid, processing_done, busy
    );
endinterface

// File: rtl/dot_product_unit.sv
// One-shot sequencer: fetches A[i]/B[i] alternately from a registered-read memory,
// multiply-accumulates them and presents the dot product to mem_writer.
module dot_product_unit #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int RESULT_WIDTH = 2*DATA_WIDTH + $clog2(VECTOR_WIDTH)
) (
    input logic               clk,
    input logic               rst_n,
    dot_product_unit_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(2*VECTOR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST_READ = CNT_WIDTH'(2*VECTOR_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, RESULT, DONE} state_t;

    state_t                  state, state_next;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [ADDR_WIDTH-1:0]   base_a, base_b;
    logic [DATA_WIDTH-1:0]   a_reg;
    logic [RESULT_WIDTH-1:0] acc, acc_next, result;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ADDR_WIDTH-1:0]   fetch_addr, elem_idx;
    logic                    pend_valid, pend_is_b;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: defaulting state_next before the case keeps this block purely
    // combinational; a missing default path would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = FETCH;
            FETCH:   if (cnt == LAST_READ) state_next = DRAIN;
            DRAIN:   state_next = RESULT;
            RESULT:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Even counts address A[i], odd counts address B[i]; wrap is modulo 2^ADDR_WIDTH.
    assign elem_idx   = ADDR_WIDTH'(cnt >> 1);
    assign fetch_addr = cnt[0] ? (base_b + elem_idx) : (base_a + elem_idx);

    always_comb begin
        bus.read_en         = (state == FETCH);
        bus.read_address    = (state == FETCH) ? fetch_addr : '0;
        bus.result_valid    = (state == RESULT);
        bus.processing_done = (state == DONE);
        bus.busy            = (state != IDLE);
    end

    assign bus.dot_product_result = result;

    assign prod     = (2*DATA_WIDTH)'(a_reg) * (2*DATA_WIDTH)'(bus.read_data);
    assign acc_next = acc + RESULT_WIDTH'(prod);

    // Datapath: the pend_* pair tracks which element the memory returns this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            base_a     <= '0;
            base_b     <= '0;
            a_reg      <= '0;
            acc        <= '0;
            result     <= '0;
            pend_valid <= 1'b0;
            pend_is_b  <= 1'b0;
        end else begin
            pend_valid <= (state == FETCH);
            pend_is_b  <= cnt[0];

            if (state == IDLE && bus.start) begin
                base_a <= bus.base_addr_a;
                base_b <= bus.base_addr_b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == FETCH) begin
                cnt <= cnt + 1'b1;
            end

            if (pend_valid) begin
                if (pend_is_b) acc   <= acc_next;
                else           a_reg <= bus.read_data;
            end

            // The last B element lands during DRAIN, so the result takes the updated sum.
            if (state == DRAIN) result <= acc_next;
        end
    end
endmodule
